trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture.sv | 216 +++++++++++++++++++++
 tb/tb_trace_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// trace_capture: logic-analyser style capture buffer with a byte-wide readout.
//
// Arming clears the ring buffer and latches post_count. While ARMED or POST
// every qualified sample is written to a DEPTH-entry ring. A qualified trigger
// in ARMED starts the post-trigger phase. Once the remaining post_count
// samples have been recorded, the block enters DUMP and streams the newest
// min(fill, DEPTH) entries, oldest first, least-significant byte first.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   arm               start request, honoured only in IDLE
//   abort             highest-priority return to IDLE
//   sample/sample_en  probe word and its qualifier
//   trig              trigger condition, qualified by sample_en
//   post_count        qualified samples to keep after the trigger (latched on arm)
//   armed, triggered  status: ARMED / (POST or DUMP)
//   rd_data/rd_valid/rd_ready/rd_last   byte readout stream
//   dbg_state         current FSM state (0 IDLE, 1 ARMED, 2 POST, 3 DUMP)
//
// Readout handshake: a byte moves on a rising edge where rd_valid and
// rd_ready are both high; while rd_valid is high and rd_ready is low the
// outputs rd_data, rd_valid and rd_last hold stable.
module trace_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DATA_W-1:0]        sample,
  input  logic                     sample_en,
  input  logic                     trig,
  input  logic [$clog2(DEPTH)-1:0] post_count,
  output logic                     armed,
  output logic                     triggered,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Capture side
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] post_q, post_d;
  logic          we;

  // Readout side: RAM read register is stage 1, the byte serialiser stage 2
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       rd_left_q, rd_left_d;
  logic              v1_q, v1_d;
  logic              v1_last_q, v1_last_d;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] word_q, word_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              last_ent_q, last_ent_d;

  logic fire, last_byte, load2, ren, enter_dump;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (sample_en) begin
        we = 1'b1;
        if (trig) state_d = (post_q == '0) ? S_DUMP : S_POST;
      end
      S_POST:  if (sample_en) begin
        we = 1'b1;
        if (post_q == AW'(1)) state_d = S_DUMP;
      end
      S_DUMP:  if (fire && rd_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      we      = 1'b0;
    end
  end

  // ---------------------------------------------------------------- datapath
  assign fire      = valid_q & rd_ready;
  assign last_byte = (byte_q == BW'(NB - 1));
  assign rd_last   = valid_q & last_ent_q & last_byte;
  // Stage 2 takes a new word when empty or when its final byte leaves now.
  assign load2      = v1_q & (~valid_q | (fire & last_byte));
  // Stage 1 reads ahead whenever its slot is free or being emptied.
  assign ren        = (state_q == S_DUMP) & (rd_left_q != '0) & (~v1_q | load2);
  assign enter_dump = (state_q != S_DUMP) & (state_d == S_DUMP);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    v1_d       = v1_q;
    v1_last_d  = v1_last_q;
    valid_d    = valid_q;
    word_d     = word_q;
    byte_d     = byte_q;
    last_ent_d = last_ent_q;

    if (state_q == S_IDLE && state_d == S_ARMED) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      post_d   = post_count;
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != (AW + 1)'(DEPTH)) fill_d = fill_q + 1'b1;
      if (state_q == S_POST) post_d = post_q - 1'b1;
    end

    // DUMP is always entered on a write cycle, so use the post-write pointers.
    // When fill == DEPTH its low bits are zero and the oldest entry is wr_ptr.
    if (enter_dump) begin
      rd_ptr_d  = wr_ptr_d - fill_d[AW-1:0];
      rd_left_d = fill_d;
    end else if (ren) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
    end

    if (ren) begin
      v1_d      = 1'b1;
      v1_last_d = (rd_left_q == (AW + 1)'(1));
    end else if (load2) begin
      v1_d = 1'b0;
    end

    if (load2) begin
      valid_d    = 1'b1;
      word_d     = ram_q;
      byte_d     = '0;
      last_ent_d = v1_last_q;
    end else if (fire) begin
      if (last_byte) begin
        valid_d = 1'b0;
      end else begin
        byte_d = byte_q + 1'b1;
        word_d = word_q >> 8;
      end
    end

    // Leaving DUMP (done, abort) drops anything still in flight.
    if (state_d != S_DUMP) begin
      v1_d    = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      v1_q       <= 1'b0;
      v1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      byte_q     <= '0;
      last_ent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      v1_q       <= v1_d;
      v1_last_q  <= v1_last_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      last_ent_q <= last_ent_d;
    end
  end

  // Buffer RAM: no reset; stale contents are unreachable because fill restarts at 0.
  always_ff @(posedge clk) begin
    if (we)  mem[wr_ptr_q] <= sample;
    if (ren) ram_q         <= mem[rd_ptr_q];
  end

  assign armed     = (state_q == S_ARMED);
  assign triggered = (state_q == S_POST) || (state_q == S_DUMP);
  assign rd_valid  = valid_q;
  assign rd_data   = valid_q ? word_q[7:0] : 8'h00;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  localparam int DW = 16;
  localparam int DP = 8;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          abort;
  logic [DW-1:0] sample;
  logic          sample_en;
  logic          trig;
  logic [2:0]    post_count;
  logic          armed;
  logic          triggered;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0]    exp_q[$];
  logic [DW-1:0] rec_q[$];

  typedef struct {
    int            n_samp;
    int            trig_at;
    int            post;
    logic [DW-1:0] base;
    bit            rnd;
    int            exp_ent;
    logic [DW-1:0] exp_first;
  } vec_t;

  vec_t tbl[6];

  trace_capture #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .sample     (sample),
    .sample_en  (sample_en),
    .trig       (trig),
    .post_count (post_count),
    .armed      (armed),
    .triggered  (triggered),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .dbg_state  (dbg_state)
  );

  // ------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ------------------------------------------------ helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " armed"},     32'(armed),     0);
    check({tag, " triggered"}, 32'(triggered), 0);
    check({tag, " rd_valid"},  32'(rd_valid),  0);
    check({tag, " rd_last"},   32'(rd_last),   0);
    check({tag, " rd_data"},   32'(rd_data),   0);
    check({tag, " state"},     32'(dbg_state), 0);
  endtask

  // ------------------------------------------------ drivers
  task automatic step(input bit a, input bit en, input bit t, input logic [DW-1:0] d);
    arm       = a;
    sample_en = en;
    trig      = t;
    sample    = d;
    tick();
    arm       = 1'b0;
    sample_en = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic arm_with(input int p);
    post_count = 3'(p);
    step(1'b1, 1'b0, 1'b0, '0);
    check("arm armed", 32'(armed), 1);
  endtask

  // Expected bytes of a run of consecutive words, LSB first.
  task automatic exp_from_run(input logic [DW-1:0] first, input int n);
    logic [DW-1:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = first + DW'(i);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  // Reference model: the dump is the newest min(recorded, DEPTH) words.
  task automatic exp_from_model();
    int start;
    exp_q.delete();
    start = (rec_q.size() > DP) ? rec_q.size() - DP : 0;
    for (int i = start; i < rec_q.size(); i++) begin
      exp_q.push_back(rec_q[i][7:0]);
      exp_q.push_back(rec_q[i][15:8]);
    end
  endtask

  // Scoreboard for one dump; called right after the edge that enters DUMP.
  task automatic collect(input bit rnd, input string tag);
    bit         done, seen, pv, pr, rdy;
    int         lat;
    logic [7:0] pd, e;
    logic       pl;
    done = 0; seen = 0; pv = 0; pr = 0; lat = 0; pd = '0; pl = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (pv && !pr) begin
        check({tag, " stall rd_valid"}, 32'(rd_valid), 1);
        check({tag, " stall rd_data"},  32'(rd_data),  32'(pd));
        check({tag, " stall rd_last"},  32'(rd_last),  32'(pl));
      end
      if (!seen) begin
        if (rd_valid) begin
          seen = 1;
          check({tag, " first valid within 3"}, 32'(lat <= 3), 1);
        end else begin
          lat++;
        end
      end
      rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = rdy;
      if (rd_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra byte"}, 32'(rd_data), 32'hxx);
        end else begin
          e = exp_q.pop_front();
          check({tag, " byte"},    32'(rd_data), 32'(e));
          check({tag, " rd_last"}, 32'(rd_last), 32'(exp_q.size() == 0));
        end
        if (rd_last) done = 1;
      end
      pv = rd_valid; pr = rdy; pd = rd_data; pl = rd_last;
      tick();
    end
    rd_ready = 1'b0;
    check({tag, " dump finished"},  32'(done),         1);
    check({tag, " bytes missing"},  32'(exp_q.size()), 0);
    check({tag, " idle after"},     32'(dbg_state),    0);
    check({tag, " valid after"},    32'(rd_valid),     0);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    arm_with(v.post);
    for (int i = 0; i < v.n_samp; i++)
      step(1'b0, 1'b1, (i == v.trig_at), v.base + DW'(i));
    check({tag, " in dump"},   32'(dbg_state), 3);
    check({tag, " triggered"}, 32'(triggered), 1);
    exp_from_run(v.exp_first, v.exp_ent);
    collect(v.rnd, tag);
  endtask

  // Capture a 3-entry trace and wait (bounded) for the first readout byte.
  task automatic start_short_dump(input logic [DW-1:0] base);
    int n;
    arm_with(0);
    step(1'b0, 1'b1, 1'b0, base);
    step(1'b0, 1'b1, 1'b0, base + 1);
    step(1'b0, 1'b1, 1'b1, base + 2);
    n = 0;
    while (!rd_valid && n < 5) begin
      tick();
      n++;
    end
    check("short dump valid", 32'(rd_valid), 1);
  endtask

  // ------------------------------------------------ test
  initial begin
    tbl[0] = '{n_samp: 4,  trig_at: 1,  post: 2, base: 16'h0001, rnd: 0, exp_ent: 4, exp_first: 16'h0001};
    tbl[1] = '{n_samp: 12, trig_at: 11, post: 0, base: 16'h0010, rnd: 0, exp_ent: 8, exp_first: 16'h0014};
    tbl[2] = '{n_samp: 12, trig_at: 11, post: 0, base: 16'h0010, rnd: 1, exp_ent: 8, exp_first: 16'h0014};
    tbl[3] = '{n_samp: 1,  trig_at: 0,  post: 0, base: 16'h55AA, rnd: 0, exp_ent: 1, exp_first: 16'h55AA};
    tbl[4] = '{n_samp: 8,  trig_at: 0,  post: 7, base: 16'h0300, rnd: 1, exp_ent: 8, exp_first: 16'h0300};
    tbl[5] = '{n_samp: 13, trig_at: 5,  post: 7, base: 16'hFFF8, rnd: 0, exp_ent: 8, exp_first: 16'hFFFD};

    rst_n = 1'b0; arm = 0; abort = 0; sample = '0; sample_en = 0; trig = 0;
    post_count = '0; rd_ready = 0;
    tick(); tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven captures
    for (int i = 0; i < 6; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    // Unqualified trig and a second arm while ARMED are ignored
    arm_with(0);
    step(1'b0, 1'b0, 1'b1, 16'h9999);
    check("trig w/o en armed",    32'(armed),     1);
    check("trig w/o en trig",     32'(triggered), 0);
    step(1'b0, 1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rearm state", 32'(dbg_state), 1);
    step(1'b0, 1'b1, 1'b1, 16'h2222);
    check("rearm dump", 32'(dbg_state), 3);
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h22);
    collect(1'b0, "rearm");

    // Abort in POST
    arm_with(3);
    step(1'b0, 1'b1, 1'b1, 16'h0A0A);
    check("post state", 32'(dbg_state), 2);
    step(1'b0, 1'b1, 1'b0, 16'h0B0B);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort post");
    run_case(tbl[0], "after abort post");

    // Abort in DUMP with a byte on offer
    start_short_dump(16'h0500);
    rd_ready = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    rd_ready = 1'b0;
    check_idle("abort dump");
    tick();
    check("abort dump later valid", 32'(rd_valid), 0);

    // Reset mid-dump
    start_short_dump(16'h0700);
    rd_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_idle("reset mid dump");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post reset valid", 32'(rd_valid), 0);
    end
    rd_ready = 1'b0;
    run_case(tbl[0], "after reset");

    // Randomized captures against the reference model
    for (int it = 0; it < 10; it++) begin
      int            p, n_pre, got, guard;
      bit            en, t, a;
      logic [DW-1:0] d;
      p = $urandom_range(0, 7);
      rec_q.delete();
      arm_with(p);
      n_pre = $urandom_range(0, 12);
      for (int k = 0; k < n_pre; k++) begin
        en = 1'($urandom_range(0, 1));
        t  = en ? 1'b0 : 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 3) == 0);
        d  = DW'($urandom);
        step(a, en, t, d);
        if (en) rec_q.push_back(d);
      end
      check("rand armed", 32'(armed), 1);
      d = DW'($urandom);
      step(1'b0, 1'b1, 1'b1, d);
      rec_q.push_back(d);
      check("rand after trig", 32'(dbg_state), (p == 0) ? 3 : 2);
      got = 0; guard = 0;
      while (got < p) begin
        en = (guard > 50) ? 1'b1 : 1'($urandom_range(0, 1));
        t  = 1'($urandom_range(0, 1));
        a  = 1'($urandom_range(0, 1));
        d  = DW'($urandom);
        step(a, en, t, d);
        if (en) begin
          rec_q.push_back(d);
          got++;
        end
        guard++;
      end
      check("rand in dump", 32'(dbg_state), 3);
      exp_from_model();
      collect(1'b1, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
